// File: rtl/mem_store_controller_if.sv
// Bus bundle for mem_store_controller: command input, IM/DM read port and external memory write port.
interface mem_store_controller_if;
    logic [35:0] rom_ir;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        src_enable;
    logic        src_en_read;
    logic        src_sel;
    logic [9:0]  src_addr;
    logic [31:0] src_rdata;
    logic        mem_enable;
    logic        mem_en_write;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [15:0] total_words;
    logic        store_done;
    logic        cmd_err;
    logic        eop;

    modport master (
        input  rom_ir, cmd_valid, src_rdata, mem_ready,
        output cmd_ready, src_enable, src_en_read, src_sel, src_addr,
               mem_enable, mem_en_write, mem_addr, mem_wdata,
               total_words, store_done, cmd_err, eop
    );

    modport slave (
        output rom_ir, cmd_valid, src_rdata, mem_ready,
        input  cmd_ready, src_enable, src_en_read, src_sel, src_addr,
               mem_enable, mem_en_write, mem_addr, mem_wdata,
               total_words, store_done, cmd_err, eop
    );
endinterface

// File: rtl/mem_store_controller.sv
// Write-back controller: copies size>>5 consecutive IM/DM words to external memory,
// one read / capture / write triple per word.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | cmd_ready=1, decode and accept one command
// S_READ    | strobe IM/DM read at src_addr
// S_CAPTURE | register src_rdata into mem_wdata
// S_WRITE   | hold write strobe until mem_ready, then advance addresses
// S_DONE    | set store_done, return to IDLE
module mem_store_controller #(
    parameter logic [9:0] IM_START = 10'h080,
    parameter logic [9:0] DM_START = 10'h000
) (
    input  logic                   clock,
    input  logic                   reset,
    mem_store_controller_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_WRITE,
        S_DONE
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] word_cnt;
    logic        accept;
    logic        cmd_zero;
    logic        cmd_rst;
    logic        cmd_en;
    logic        cmd_sel;
    logic        cmd_read;
    logic [15:0] cmd_start;
    logic [15:0] cmd_words;
    logic        cmd_store;
    logic        cmd_load;
    logic        wr_accept;
    logic        last_word;

    assign accept    = bus.cmd_valid && (state == S_IDLE);
    assign cmd_zero  = (bus.rom_ir == 36'd0);
    assign cmd_rst   = bus.rom_ir[35];
    assign cmd_en    = bus.rom_ir[34];
    assign cmd_sel   = bus.rom_ir[33];
    assign cmd_read  = bus.rom_ir[32];
    assign cmd_start = bus.rom_ir[31:16];
    assign cmd_words = {5'd0, bus.rom_ir[15:5]};

    // Decode priority: all-zero end marker, then rst, then en, then direction.
    assign cmd_store = accept && !cmd_zero && !cmd_rst && cmd_en && !cmd_read;
    assign cmd_load  = accept && !cmd_zero && !cmd_rst && cmd_en &&  cmd_read;
    assign wr_accept = (state == S_WRITE) && bus.mem_ready;
    assign last_word = (word_cnt == bus.total_words - 16'd1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (cmd_store) state_nxt = (cmd_words == 16'd0) ? S_DONE : S_READ;
            S_READ:    state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = S_WRITE;
            S_WRITE:   if (bus.mem_ready) state_nxt = last_word ? S_DONE : S_READ;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_ready    = 1'b0;
        bus.src_enable   = 1'b0;
        bus.src_en_read  = 1'b0;
        bus.mem_enable   = 1'b0;
        bus.mem_en_write = 1'b0;
        case (state)
            S_IDLE:  bus.cmd_ready = 1'b1;
            S_READ: begin
                bus.src_enable  = 1'b1;
                bus.src_en_read = 1'b1;
            end
            S_WRITE: begin
                bus.mem_enable   = 1'b1;
                bus.mem_en_write = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.src_sel     <= 1'b0;
            bus.src_addr    <= 10'd0;
            bus.mem_addr    <= 14'd0;
            bus.mem_wdata   <= 32'd0;
            bus.total_words <= 16'd0;
            bus.store_done  <= 1'b0;
            bus.cmd_err     <= 1'b0;
            bus.eop         <= 1'b0;
            word_cnt        <= 16'd0;
        end else begin
            if (accept && cmd_zero) bus.eop <= 1'b1;
            if (accept && !cmd_zero && cmd_rst) begin
                bus.store_done <= 1'b0;
                bus.cmd_err    <= 1'b0;
            end
            if (cmd_load) bus.cmd_err <= 1'b1;
            if (cmd_store) begin
                bus.src_sel     <= cmd_sel;
                bus.total_words <= cmd_words;
                bus.mem_addr    <= cmd_start[13:0];
                bus.src_addr    <= cmd_sel ? DM_START : IM_START;
                bus.store_done  <= 1'b0;
                word_cnt        <= 16'd0;
            end
            if (state == S_CAPTURE) bus.mem_wdata <= bus.src_rdata;
            // IM is byte addressed, DM is word addressed.
            if (wr_accept) begin
                word_cnt     <= word_cnt + 16'd1;
                bus.mem_addr <= bus.mem_addr + 14'd1;
                bus.src_addr <= bus.src_addr + (bus.src_sel ? 10'd1 : 10'd4);
            end
            if (state == S_DONE) bus.store_done <= 1'b1;
        end
    end
endmodule
